jtag_burst_master: RTL and testbench

Parametrised bus-master engine between the JTAG command decoder and the Gecko5 system bus. It accepts single-word or burst read/write commands over a valid/ready handshake, arbitrates for the bus, and executes the transfer. Write data is streamed in and read data is buffered in an internal FIFO with back-pressure. It reports completion, bus errors and, optionally, watchdog timeouts. It replaces the fixed single-transfer bus logic inside the JTAG support path and sits between the JTAG-side command decoder (already in `system_clock` domain) and the arbiter/bus.

---
 rtl/jtag_burst_master.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_jtag_burst_master.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_burst_master.sv
// jtag_burst_master
//
// Bus-master engine between the JTAG command decoder and the Gecko5 system
// bus. A command (single word or burst, read or write) is taken over a
// valid/ready handshake. The engine then requests the bus, issues the
// transaction and streams the data beats. Read data lands in an internal
// FIFO that drains on its own handshake. The FIFO back-pressures the slave
// through busyOUT.
//
// Optional feature: define JTAG_BUS_TIMEOUT_EN to add a watchdog. The
// watchdog aborts a transfer that sees no grant, beat or end for
// TIMEOUT_CYCLES cycles. Without the macro the engine waits indefinitely.
//
// Ports
//   system_clock, system_reset_n : clock, synchronous active-low reset
//   cmd_*                        : command handshake (write flag, word
//                                  address, beats-1, byte enables)
//   wdata_valid/ready, wdata     : write-data stream into the engine
//   rdata_valid/ready, rdata     : read-data stream out of the FIFO
//   done, status                 : completion pulse; status 00 ok,
//                                  01 bus error, 10 timeout, 11 rejected
//   request, granted             : arbiter handshake
//   *OUT                         : bus drive (all zero outside a transfer)
//   *IN                          : bus sample
module jtag_burst_master #(
  parameter int MAX_BURST      = 16,
  parameter int FIFO_DEPTH     = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        system_clock,
  input  logic        system_reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_address,
  input  logic [7:0]  cmd_burst_len,
  input  logic [3:0]  cmd_byte_enable,
  input  logic        wdata_valid,
  output logic        wdata_ready,
  input  logic [31:0] wdata,
  output logic        rdata_valid,
  input  logic        rdata_ready,
  output logic [31:0] rdata,
  output logic        done,
  output logic [1:0]  status,
  output logic        request,
  input  logic        granted,
  output logic [31:0] address_dataOUT,
  output logic [3:0]  byte_enableOUT,
  output logic [7:0]  burst_sizeOUT,
  output logic        read_n_writeOUT,
  output logic        begin_transactionOUT,
  output logic        end_transactionOUT,
  output logic        data_validOUT,
  output logic        busyOUT,
  input  logic [31:0] address_dataIN,
  input  logic        end_transactionIN,
  input  logic        data_validIN,
  input  logic        busyIN,
  input  logic        errorIN
);

  localparam int          AW        = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_W   = FIFO_DEPTH[AW:0];
  localparam int          BUSY_AT   = FIFO_DEPTH - 2;
  // Two free entries left: the slave may still land one beat after seeing busy.
  localparam logic [AW:0] BUSY_FILL = BUSY_AT[AW:0];
  localparam logic [8:0]  MAX_BEATS = MAX_BURST[8:0];

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_BUS_ERR = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;
  localparam logic [1:0] ST_REJECT  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_BEGIN, S_WRITE, S_READ, S_END, S_DONE
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  code_q, code_nxt, status_q;

  // Latched command
  logic        wr_q;
  logic [31:0] addr_q;
  logic [7:0]  len_q;
  logic [3:0]  be_q;

  // Write beat staging
  logic [8:0]  load_cnt, xfer_cnt;
  logic        pend_q;
  logic [31:0] wbeat_q;

  // Read FIFO; pointers carry one extra wrap bit
  logic [31:0] mem [FIFO_DEPTH];
  logic [AW:0] wptr, rptr, rptr_nxt, fifo_fill;
  logic [31:0] rdata_q;

  logic        cmd_accept, too_long;
  logic [8:0]  beats_req;
  logic        wbeat_load, wbeat_xfer;
  logic        fifo_full, fifo_push, fifo_pop, fifo_drop;
  logic        wd_hit;

  assign cmd_accept = (state == S_IDLE) && cmd_valid;
  assign beats_req  = {1'b0, cmd_burst_len} + 9'd1;
  assign too_long   = beats_req > MAX_BEATS;

  // The next beat may load in the same cycle the current one leaves, which
  // keeps an unstalled burst at one beat per cycle.
  assign wbeat_xfer  = (state == S_WRITE) && pend_q && !busyIN;
  assign wdata_ready = (state == S_WRITE) && (load_cnt != 9'd0) && (!pend_q || wbeat_xfer);
  assign wbeat_load  = wdata_valid && wdata_ready;

  assign fifo_fill = wptr - rptr;
  assign fifo_full = (fifo_fill == DEPTH_W);
  assign fifo_pop  = (fifo_fill != '0) && rdata_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign fifo_push = (state == S_READ) && data_validIN && (!fifo_full || fifo_pop);
  assign fifo_drop = (state == S_READ) && data_validIN && fifo_full && !fifo_pop;
  assign rptr_nxt  = rptr + {{AW{1'b0}}, fifo_pop};

`ifdef JTAG_BUS_TIMEOUT_EN
  localparam int             WW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam int             WD_LAST = TIMEOUT_CYCLES - 1;
  localparam logic [WW-1:0]  WD_END  = WD_LAST[WW-1:0];

  logic [WW-1:0] wd_cnt;
  logic          wd_active, wd_evt;

  assign wd_active = (state == S_REQ) || (state == S_WRITE) || (state == S_READ);
  assign wd_evt    = ((state == S_REQ) && granted) || wbeat_xfer ||
                     ((state == S_READ) && (data_validIN || end_transactionIN));
  assign wd_hit    = wd_active && !wd_evt && (wd_cnt == WD_END);

  always_ff @(posedge system_clock) begin
    if (!system_reset_n || !wd_active || wd_evt) wd_cnt <= '0;
    else                                          wd_cnt <= wd_cnt + 1'b1;
  end
`else
  assign wd_hit = 1'b0;
`endif

  // Next state and completion code
  always_comb begin
    state_nxt = state;
    code_nxt  = code_q;
    case (state)
      S_IDLE: begin
        if (cmd_accept) begin
          if (too_long) begin
            state_nxt = S_DONE;
            code_nxt  = ST_REJECT;
          end else begin
            state_nxt = S_REQ;
            code_nxt  = ST_OK;
          end
        end
      end
      S_REQ: begin
        if (granted) state_nxt = S_BEGIN;
        else if (wd_hit) begin
          // Bus never owned: just drop the request, no end_transaction.
          state_nxt = S_DONE;
          code_nxt  = ST_TIMEOUT;
        end
      end
      S_BEGIN: begin
        if (errorIN) begin
          code_nxt  = ST_BUS_ERR;
          state_nxt = wr_q ? S_END : S_DONE;
        end else begin
          state_nxt = wr_q ? S_WRITE : S_READ;
        end
      end
      S_WRITE: begin
        if (errorIN) begin
          code_nxt  = ST_BUS_ERR;
          state_nxt = S_END;
        end else if (wbeat_xfer && (xfer_cnt == 9'd1)) begin
          state_nxt = S_END;
        end else if (wd_hit) begin
          code_nxt  = ST_TIMEOUT;
          state_nxt = S_END;
        end
      end
      S_READ: begin
        if (fifo_drop) code_nxt = ST_BUS_ERR;
        if (errorIN) begin
          code_nxt  = ST_BUS_ERR;
          state_nxt = S_DONE;
        end else if (end_transactionIN) begin
          state_nxt = S_DONE;
        end else if (wd_hit) begin
          code_nxt  = ST_TIMEOUT;
          state_nxt = S_END;
        end
      end
      S_END:   state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Control registers
  always_ff @(posedge system_clock) begin
    if (!system_reset_n) begin
      state    <= S_IDLE;
      code_q   <= ST_OK;
      status_q <= ST_OK;
      pend_q   <= 1'b0;
      load_cnt <= '0;
      xfer_cnt <= '0;
      wptr     <= '0;
      rptr     <= '0;
      rdata_q  <= '0;
    end else begin
      state  <= state_nxt;
      code_q <= code_nxt;
      // DONE is always entered from another state, so this loads exactly
      // once per command and the code stays visible until the next one.
      if (state_nxt == S_DONE) status_q <= code_nxt;

      if (cmd_accept) begin
        load_cnt <= beats_req;
        xfer_cnt <= beats_req;
      end
      if (state == S_WRITE) begin
        if (wbeat_load)      pend_q <= 1'b1;
        else if (wbeat_xfer) pend_q <= 1'b0;
        if (wbeat_load) load_cnt <= load_cnt - 9'd1;
        if (wbeat_xfer) xfer_cnt <= xfer_cnt - 9'd1;
      end else begin
        pend_q <= 1'b0;
      end

      if (fifo_push) wptr <= wptr + 1'b1;
      rptr <= rptr_nxt;
      // Registered head of FIFO; bypass when the pushed word becomes the head.
      if (fifo_push && (wptr == rptr_nxt)) rdata_q <= address_dataIN;
      else                                 rdata_q <= mem[rptr_nxt[AW-1:0]];
    end
  end

  // Datapath registers (no reset needed; qualified by control state)
  always_ff @(posedge system_clock) begin
    if (cmd_accept) begin
      wr_q   <= cmd_write;
      addr_q <= cmd_address;
      len_q  <= cmd_burst_len;
      be_q   <= cmd_byte_enable;
    end
    if (wbeat_load) wbeat_q <= wdata;
    if (fifo_push)  mem[wptr[AW-1:0]] <= address_dataIN;
  end

  assign cmd_ready   = (state == S_IDLE);
  assign done        = (state == S_DONE);
  assign status      = status_q;
  assign request     = (state == S_REQ) || (state == S_BEGIN) ||
                       (state == S_WRITE) || (state == S_READ);
  assign rdata_valid = (fifo_fill != '0);
  assign rdata       = rdata_q;

  // Bus drive: zero outside the owning states (wired-OR bus)
  always_comb begin
    address_dataOUT      = '0;
    byte_enableOUT       = '0;
    burst_sizeOUT        = '0;
    read_n_writeOUT      = 1'b0;
    begin_transactionOUT = 1'b0;
    end_transactionOUT   = 1'b0;
    data_validOUT        = 1'b0;
    busyOUT              = 1'b0;
    case (state)
      S_BEGIN: begin
        begin_transactionOUT = 1'b1;
        address_dataOUT      = addr_q;
        burst_sizeOUT        = len_q;
        read_n_writeOUT      = !wr_q;
        byte_enableOUT       = be_q;
      end
      S_WRITE: begin
        data_validOUT   = pend_q;
        address_dataOUT = pend_q ? wbeat_q : 32'd0;
      end
      S_READ:  busyOUT = (fifo_fill >= BUSY_FILL);
      S_END:   end_transactionOUT = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_jtag_burst_master.sv
module tb_jtag_burst_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_address;
  logic [7:0]  cmd_burst_len;
  logic [3:0]  cmd_byte_enable;
  logic        wdata_valid, wdata_ready;
  logic [31:0] wdata;
  logic        rdata_valid, rdata_ready;
  logic [31:0] rdata;
  logic        done;
  logic [1:0]  status;
  logic        request, granted;
  logic [31:0] address_dataOUT;
  logic [3:0]  byte_enableOUT;
  logic [7:0]  burst_sizeOUT;
  logic        read_n_writeOUT, begin_transactionOUT, end_transactionOUT;
  logic        data_validOUT, busyOUT;
  logic [31:0] address_dataIN;
  logic        end_transactionIN, data_validIN, busyIN, errorIN;
  logic [48:0] bus_vec;

  int n_tests = 0;
  int n_fail  = 0;

  // Observations collected by the stimulus drivers
  int          obs_cyc, obs_req_cyc, obs_begin_cyc, obs_xfer, obs_bad, obs_unstable;
  int          obs_stall, obs_end, obs_first_busy, obs_recv, obs_sent;
  logic [31:0] obs_begin_addr;
  logic [7:0]  obs_burst;
  logic        obs_rnw, obs_req_at_done;
  logic [3:0]  obs_be;
  logic [1:0]  obs_status;
  logic [48:0] obs_bus_at_done;

  assign bus_vec = {address_dataOUT, byte_enableOUT, burst_sizeOUT, read_n_writeOUT,
                    begin_transactionOUT, end_transactionOUT, data_validOUT, busyOUT};

  jtag_burst_master #(.MAX_BURST(16), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(32)) dut (
    .system_clock(clk), .system_reset_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_address(cmd_address), .cmd_burst_len(cmd_burst_len), .cmd_byte_enable(cmd_byte_enable),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
    .done(done), .status(status), .request(request), .granted(granted),
    .address_dataOUT(address_dataOUT), .byte_enableOUT(byte_enableOUT),
    .burst_sizeOUT(burst_sizeOUT), .read_n_writeOUT(read_n_writeOUT),
    .begin_transactionOUT(begin_transactionOUT), .end_transactionOUT(end_transactionOUT),
    .data_validOUT(data_validOUT), .busyOUT(busyOUT),
    .address_dataIN(address_dataIN), .end_transactionIN(end_transactionIN),
    .data_validIN(data_validIN), .busyIN(busyIN), .errorIN(errorIN)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic clear_obs();
    obs_cyc = -1; obs_req_cyc = -1; obs_begin_cyc = -1; obs_xfer = 0; obs_bad = 0;
    obs_unstable = 0; obs_stall = 0; obs_end = 0; obs_first_busy = -1; obs_recv = 0;
    obs_sent = 0; obs_begin_addr = '0; obs_burst = '0; obs_rnw = 1'b0; obs_be = '0;
    obs_status = 2'bxx; obs_req_at_done = 1'bx; obs_bus_at_done = 'x;
  endtask

  // Issue a write command and act as write-side slave; stall_beat is 0-based.
  task automatic run_write(input logic [31:0] addr, input logic [31:0] base,
                           input int nbeats, input int stall_beat, input int stall_len);
    int cyc, nload;
    clear_obs();
    nload = 0;
    @(negedge clk);
    cmd_valid = 1; cmd_write = 1; cmd_address = addr;
    cmd_burst_len = 8'(nbeats - 1); cmd_byte_enable = 4'hA; granted = 1;
    cyc = 0;
    while (cyc < 100 && obs_cyc < 0) begin
      @(negedge clk);
      cyc++;
      cmd_valid   = 0;
      wdata_valid = (nload < nbeats);
      wdata       = base + 32'(nload);
      busyIN      = data_validOUT && (obs_xfer == stall_beat) && (obs_stall < stall_len);
      #1;
      if (request && obs_req_cyc < 0) obs_req_cyc = cyc;
      if (begin_transactionOUT) begin
        obs_begin_cyc = cyc; obs_begin_addr = address_dataOUT; obs_burst = burst_sizeOUT;
        obs_rnw = read_n_writeOUT; obs_be = byte_enableOUT;
      end
      if (wdata_valid && wdata_ready) nload++;
      if (data_validOUT) begin
        if (address_dataOUT !== base + 32'(obs_xfer)) begin
          if (busyIN) obs_unstable++;
          else        obs_bad++;
        end
        if (busyIN) obs_stall++;
        else        obs_xfer++;
      end
      if (end_transactionOUT) obs_end++;
      if (done) begin obs_cyc = cyc; obs_status = status; end
    end
    wdata_valid = 0; busyIN = 0; granted = 0;
  endtask

  // Issue a read command and act as read-side slave reacting to busyOUT one
  // cycle late; err_after >= 0 raises errorIN after that many beats.
  task automatic run_read(input logic [31:0] addr, input logic [31:0] base, input int nbeats,
                          input int err_after, input int ready_cyc);
    int cyc;
    bit begun, ended, errd, busy_prev;
    clear_obs();
    begun = 0; ended = 0; errd = 0; busy_prev = 0;
    @(negedge clk);
    cmd_valid = 1; cmd_write = 0; cmd_address = addr;
    cmd_burst_len = 8'(nbeats - 1); cmd_byte_enable = 4'hF; granted = 1; rdata_ready = 0;
    cyc = 0;
    while (cyc < 300 && !(obs_cyc >= 0 && obs_recv >= obs_sent)) begin
      @(negedge clk);
      cyc++;
      cmd_valid = 0;
      data_validIN = begun && obs_cyc < 0 && !ended && obs_sent < nbeats && !busy_prev &&
                     !(err_after >= 0 && obs_sent == err_after);
      errorIN = begun && obs_cyc < 0 && err_after >= 0 && obs_sent == err_after && !errd;
      end_transactionIN = begun && obs_cyc < 0 && !ended && obs_sent == nbeats;
      address_dataIN = base + 32'(obs_sent);
      rdata_ready = (cyc >= ready_cyc);
      #1;
      if (busyOUT && obs_first_busy < 0) obs_first_busy = obs_sent;
      busy_prev = busyOUT;
      if (data_validIN) obs_sent++;
      if (errorIN) errd = 1;
      if (end_transactionIN) ended = 1;
      if (rdata_valid && rdata_ready) begin
        if (rdata !== base + 32'(obs_recv)) obs_bad++;
        obs_recv++;
      end
      if (begin_transactionOUT) begin
        begun = 1; obs_rnw = read_n_writeOUT; obs_burst = burst_sizeOUT;
      end
      if (done) begin
        obs_cyc = cyc; obs_status = status; obs_req_at_done = request; obs_bus_at_done = bus_vec;
      end
    end
    data_validIN = 0; errorIN = 0; end_transactionIN = 0; granted = 0; rdata_ready = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (2) @(negedge clk);
    #1;
    n_tests++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
    n_tests++; if ({request, done, wdata_ready, rdata_valid} !== 4'b0) begin n_fail++; $display("FAIL reset_ctrl_outs: got %b expected 0000", {request, done, wdata_ready, rdata_valid}); end
    n_tests++; if (status !== 2'b00) begin n_fail++; $display("FAIL reset_status: got %b expected 00", status); end
    n_tests++; if (bus_vec !== 49'd0) begin n_fail++; $display("FAIL reset_bus: got %h expected 0", bus_vec); end
    n_tests++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
    rst_n = 1;
  endtask

  task automatic test_single_write();
    run_write(32'h0000_0100, 32'hDEAD_BEEF, 1, -1, 0);
    n_tests++; if (obs_req_cyc !== 1) begin n_fail++; $display("FAIL sw_request_latency: got %0d expected 1", obs_req_cyc); end
    n_tests++; if (obs_begin_cyc !== 2) begin n_fail++; $display("FAIL sw_begin_cycle: got %0d expected 2", obs_begin_cyc); end
    n_tests++; if ({obs_begin_addr, obs_burst, obs_rnw, obs_be} !== {32'h100, 8'd0, 1'b0, 4'hA}) begin n_fail++; $display("FAIL sw_begin_fields: got %h/%h/%b/%h expected 100/00/0/a", obs_begin_addr, obs_burst, obs_rnw, obs_be); end
    n_tests++; if (obs_xfer !== 1 || obs_bad !== 0) begin n_fail++; $display("FAIL sw_beat: got %0d beats %0d bad expected 1 beats 0 bad", obs_xfer, obs_bad); end
    n_tests++; if (obs_end !== 1) begin n_fail++; $display("FAIL sw_end_transaction: got %0d expected 1", obs_end); end
    n_tests++; if (obs_cyc !== 6) begin n_fail++; $display("FAIL sw_done_cycle: got %0d expected 6", obs_cyc); end
    n_tests++; if (obs_status !== 2'b00) begin n_fail++; $display("FAIL sw_status: got %b expected 00", obs_status); end
  endtask

  task automatic test_write_burst();
    run_write(32'h0000_2000, 32'hC0DE_0000, 8, 3, 3);
    n_tests++; if (obs_xfer !== 8 || obs_bad !== 0) begin n_fail++; $display("FAIL wb_beats: got %0d beats %0d bad expected 8 beats 0 bad", obs_xfer, obs_bad); end
    n_tests++; if (obs_stall !== 3 || obs_unstable !== 0) begin n_fail++; $display("FAIL wb_stall_hold: got %0d stalls %0d unstable expected 3 stalls 0 unstable", obs_stall, obs_unstable); end
    n_tests++; if (obs_cyc !== 16 || obs_status !== 2'b00) begin n_fail++; $display("FAIL wb_done: got cycle %0d status %b expected cycle 16 status 00", obs_cyc, obs_status); end
    // Largest legal burst, unstalled: N+5 cycles
    run_write(32'h0000_3000, 32'h1234_0000, 16, -1, 0);
    n_tests++; if (obs_xfer !== 16 || obs_bad !== 0) begin n_fail++; $display("FAIL wb16_beats: got %0d beats %0d bad expected 16 beats 0 bad", obs_xfer, obs_bad); end
    n_tests++; if (obs_cyc !== 21 || obs_status !== 2'b00) begin n_fail++; $display("FAIL wb16_done: got cycle %0d status %b expected cycle 21 status 00", obs_cyc, obs_status); end
  endtask

  task automatic test_read_burst();
    run_read(32'h0000_4000, 32'hA000_0000, 16, -1, 20);
    n_tests++; if (obs_rnw !== 1'b1 || obs_burst !== 8'd15) begin n_fail++; $display("FAIL rb_begin: got rnw %b burst %0d expected rnw 1 burst 15", obs_rnw, obs_burst); end
    n_tests++; if (obs_first_busy !== 2) begin n_fail++; $display("FAIL rb_busy_level: got %0d entries expected 2", obs_first_busy); end
    n_tests++; if (obs_recv !== 16 || obs_bad !== 0) begin n_fail++; $display("FAIL rb_words: got %0d words %0d bad expected 16 words 0 bad", obs_recv, obs_bad); end
    n_tests++; if (obs_status !== 2'b00) begin n_fail++; $display("FAIL rb_status: got %b expected 00", obs_status); end
  endtask

  task automatic test_read_error();
    run_read(32'h0000_5000, 32'hB000_0000, 8, 2, 0);
    n_tests++; if (obs_status !== 2'b01) begin n_fail++; $display("FAIL re_status: got %b expected 01", obs_status); end
    n_tests++; if (obs_req_at_done !== 1'b0 || obs_bus_at_done !== 49'd0) begin n_fail++; $display("FAIL re_bus_release: got req %b bus %h expected req 0 bus 0", obs_req_at_done, obs_bus_at_done); end
    n_tests++; if (obs_recv !== 2 || obs_bad !== 0) begin n_fail++; $display("FAIL re_words: got %0d words %0d bad expected 2 words 0 bad", obs_recv, obs_bad); end
  endtask

  task automatic test_reject();
    logic [7:0] lens [2];
    lens[0] = 8'd200; lens[1] = 8'd16;
    for (int k = 0; k < 2; k++) begin
      int  dcyc;
      bit  saw_req;
      logic rdy_at_done;
      dcyc = -1; saw_req = 0; rdy_at_done = 1'bx;
      @(negedge clk);
      cmd_valid = 1; cmd_write = 1; cmd_address = 32'h0000_6000;
      cmd_burst_len = lens[k]; cmd_byte_enable = 4'hF; granted = 1;
      #1;
      n_tests++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rj_ready_%0d: got %b expected 1", lens[k], cmd_ready); end
      for (int c = 1; c <= 6 && dcyc < 0; c++) begin
        @(negedge clk);
        cmd_valid = 0;
        #1;
        if (request) saw_req = 1;
        if (done) begin dcyc = c; rdy_at_done = cmd_ready; end
      end
      n_tests++; if (dcyc !== 1 || status !== 2'b11) begin n_fail++; $display("FAIL rj_done_%0d: got cycle %0d status %b expected cycle 1 status 11", lens[k], dcyc, status); end
      n_tests++; if (saw_req !== 1'b0 || rdy_at_done !== 1'b0) begin n_fail++; $display("FAIL rj_no_bus_%0d: got req %b ready %b expected req 0 ready 0", lens[k], saw_req, rdy_at_done); end
      granted = 0;
      repeat (2) @(negedge clk);
      #1;
      n_tests++; if (status !== 2'b11 || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rj_status_hold_%0d: got status %b ready %b expected 11 1", lens[k], status, cmd_ready); end
    end
  endtask

  task automatic test_watchdog();
    int req_cnt, dcyc;
    req_cnt = 0; dcyc = -1;
    @(negedge clk);
    cmd_valid = 1; cmd_write = 0; cmd_address = 32'h0000_7000;
    cmd_burst_len = 8'd0; cmd_byte_enable = 4'hF; granted = 0;
`ifdef JTAG_BUS_TIMEOUT_EN
    for (int c = 1; c <= 60 && dcyc < 0; c++) begin
      @(negedge clk);
      cmd_valid = 0;
      #1;
      if (request) req_cnt++;
      if (done) dcyc = c;
    end
    n_tests++; if (req_cnt !== 32) begin n_fail++; $display("FAIL wd_request_cycles: got %0d expected 32", req_cnt); end
    n_tests++; if (dcyc !== 33 || status !== 2'b10) begin n_fail++; $display("FAIL wd_done: got cycle %0d status %b expected cycle 33 status 10", dcyc, status); end
`else
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      cmd_valid = 0;
      #1;
      if (request) req_cnt++;
      if (done) dcyc = c;
    end
    n_tests++; if (req_cnt !== 40 || dcyc !== -1) begin n_fail++; $display("FAIL wd_wait_forever: got %0d request cycles done at %0d expected 40 and none", req_cnt, dcyc); end
    // Leave the stuck REQ state
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
`endif
  endtask

  task automatic test_reset_mid();
    int ndone;
    ndone = 0;
    @(negedge clk);
    cmd_valid = 1; cmd_write = 0; cmd_address = 32'h0000_8000;
    cmd_burst_len = 8'd3; cmd_byte_enable = 4'hF; granted = 1; rdata_ready = 0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      cmd_valid = 0;
      data_validIN = (c == 3) || (c == 4);
      address_dataIN = 32'h5555_0000 + 32'(c);
    end
    data_validIN = 0;
    #1;
    n_tests++; if ({request, rdata_valid, busyOUT} !== 3'b111) begin n_fail++; $display("FAIL rm_before: got req/rvalid/busy %b expected 111", {request, rdata_valid, busyOUT}); end
    rst_n = 0;
    @(negedge clk);
    #1;
    n_tests++; if (cmd_ready !== 1'b1 || {request, done, rdata_valid, wdata_ready} !== 4'b0) begin n_fail++; $display("FAIL rm_ctrl: got ready %b others %b expected 1 0000", cmd_ready, {request, done, rdata_valid, wdata_ready}); end
    n_tests++; if (bus_vec !== 49'd0 || status !== 2'b00 || rdata !== 32'd0) begin n_fail++; $display("FAIL rm_outputs: got bus %h status %b rdata %h expected all 0", bus_vec, status, rdata); end
    rst_n = 1; granted = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      if (done) ndone++;
    end
    n_tests++; if (ndone !== 0) begin n_fail++; $display("FAIL rm_no_done: got %0d done pulses expected 0", ndone); end
  endtask

  initial begin
    cmd_valid = 0; cmd_write = 0; cmd_address = '0; cmd_burst_len = '0; cmd_byte_enable = '0;
    wdata_valid = 0; wdata = '0; rdata_ready = 0; granted = 0;
    address_dataIN = '0; end_transactionIN = 0; data_validIN = 0; busyIN = 0; errorIN = 0;
    test_reset();
    test_single_write();
    test_write_burst();
    test_read_burst();
    test_read_error();
    test_reject();
    test_watchdog();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
